// File: rtl/ahb_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_cmd_master
//
// Purpose:
//   Turns single read/write commands into AHB-Lite single transfers. Only one
//   transfer is outstanding at a time, and the address and data phases never
//   overlap. Each command produces exactly one response pulse. Illegal
//   commands complete without touching the bus.
//
// Optional feature:
//   AHBM_TIMEOUT_EN - when defined, a transfer that sees TIMEOUT consecutive
//                     HREADY-low cycles is abandoned. Its response reports
//                     rsp_err=1 and rsp_tmo=1. When undefined there is no
//                     counter, rsp_tmo is tied to 0, and the master waits on
//                     HREADY for as long as it takes.
//
// Ports:
//   HCLK, HRESET              clock; asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (accepted on valid & ready)
//   cmd_write, cmd_addr,
//   cmd_size, cmd_wdata       command fields; size 00 byte, 01 half, 10 word
//   rsp_valid                 one-cycle response pulse
//   rsp_rdata, rsp_err,
//   rsp_tmo                   response payload, valid with rsp_valid
//   HADDR..HWDATA             AHB-Lite master outputs
//   HRDATA, HREADY, HRESP     AHB-Lite master inputs
// ---------------------------------------------------------------------------
module ahb_cmd_master #(
    parameter int TIMEOUT = 1023
) (
    input  logic        HCLK,
    input  logic        HRESET,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    // response side
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_tmo,
    // AHB-Lite master
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic [1:0]  state_q, state_d;
    logic        ready_en_q;     // keeps cmd_ready low until the first edge after reset
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [2:0]  hsize_q;
    logic [31:0] hwdata_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic        accept;
    logic        cmd_illegal;
    logic        tmo_hit;        // timeout fires on this edge

    assign cmd_ready = ready_en_q && (state_q == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Misaligned or reserved-size commands never reach the bus.
    assign cmd_illegal = (cmd_size == 2'b11)
                      || ((cmd_size == 2'b01) && cmd_addr[0])
                      || ((cmd_size == 2'b10) && (cmd_addr[1:0] != 2'b00));

`ifdef AHBM_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             rsp_tmo_q;

    // The count of low cycles already seen reaches TIMEOUT on this edge.
    assign tmo_hit = ((state_q == S_ADDR) || (state_q == S_DATA))
                  && !HREADY && (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            tmo_cnt_q <= '0;
            rsp_tmo_q <= 1'b0;
        end else begin
            if (accept) begin
                tmo_cnt_q <= '0;          // fresh count on entry to ADDR
                rsp_tmo_q <= 1'b0;
            end else if ((state_q == S_ADDR) || (state_q == S_DATA)) begin
                if (HREADY || tmo_hit) begin
                    tmo_cnt_q <= '0;
                end else begin
                    tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                end
                if (tmo_hit) begin
                    rsp_tmo_q <= 1'b1;
                end
            end
        end
    end

    assign rsp_tmo = rsp_tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign rsp_tmo = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = cmd_illegal ? S_RESP : S_ADDR;
                end
            end
            S_ADDR: begin
                if (HREADY) begin
                    state_d = S_DATA;
                end else if (tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            S_DATA: begin
                if (HREADY || tmo_hit) begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            ready_en_q  <= 1'b0;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ready_en_q <= 1'b1;

            if (accept) begin
                rsp_rdata_q <= '0;
                rsp_err_q   <= cmd_illegal;
                // Bus-facing registers only follow legal commands, so the
                // address bus holds its last real value otherwise.
                if (!cmd_illegal) begin
                    haddr_q  <= cmd_addr;
                    hwrite_q <= cmd_write;
                    hsize_q  <= {1'b0, cmd_size};
                    hwdata_q <= cmd_wdata;
                end
            end

            // HRESP is only meaningful with HREADY high. The first cycle of
            // a two-cycle ERROR (HREADY low) leaves the transfer running.
            if ((state_q == S_DATA) && HREADY) begin
                rsp_err_q   <= HRESP;
                rsp_rdata_q <= (!hwrite_q && !HRESP) ? HRDATA : 32'h0;
            end

            if (tmo_hit) begin
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end
        end
    end

    // Only the address phase drives NONSEQ. A timeout exits straight to
    // RESP, so the bus returns to IDLE on the following cycle.
    assign HTRANS    = (state_q == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = haddr_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HWDATA    = hwdata_q;

    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter TIMEOUT, default 1023, number of consecutive HREADY-low cycles tolerated per transfer (used only with AHBM_TIMEOUT_EN).
REQ-002 HCLK  in  1  single clock; all state on rising edge.
REQ-003 HRESET  in  1  asynchronous, active-high reset.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising HCLK edge.
REQ-006 cmd_write  in  1  1 write, 0 read.
REQ-007 cmd_addr  in  32  byte address.
REQ-008 cmd_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 cmd_wdata  in  32  write data, lane-replicated by caller.
REQ-010 rsp_valid  out  1  one-cycle response pulse.
REQ-011 rsp_rdata  out  32  read data; 0 for writes and errors.
REQ-012 rsp_err  out  1  error status, valid with rsp_valid.
REQ-013 rsp_tmo  out  1  timeout status, valid with rsp_valid.
REQ-014 HADDR out 32, HTRANS out 2, HWRITE out 1, HSIZE out 3, HBURST out 3, HPROT out 4, HWDATA out 32: AHB-Lite master address/data outputs.
REQ-015 HRDATA in 32, HREADY in 1, HRESP in 1: AHB-Lite master inputs.

Function
REQ-016 States: IDLE, ADDR, DATA, RESP; one outstanding transfer; no address/data overlap.
REQ-017 cmd_ready SHALL be 1 only in IDLE; acceptance registers cmd_* and moves IDLE->ADDR, or IDLE->RESP for illegal commands.
REQ-018 Illegal command (cmd_size=11, halfword with addr[0]=1, word with addr[1:0]!=00): no bus transfer, RESP with rsp_err=1.
REQ-019 ADDR: HTRANS=2'b10 NONSEQ, HADDR/HWRITE registered from command, HSIZE={1'b0,cmd_size}, HBURST=000, HPROT=4'b0011; leave to DATA at edge with HREADY=1.
REQ-020 All other states: HTRANS=2'b00 IDLE; HADDR, HWRITE, HSIZE hold last values.
REQ-021 DATA: HWDATA=registered cmd_wdata; at edge with HREADY=1 capture HRDATA (reads) and HRESP into rsp_err, go RESP.
REQ-022 HRESP sampled only when HREADY=1; HRESP=1 with HREADY=0 (first error cycle) SHALL not end the transfer.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; cmd_ready=0 during RESP.
REQ-024 Zero-wait latency: accept at edge N, NONSEQ in cycle N+1, data phase N+2, rsp_valid in cycle N+3; each HREADY-low cycle adds one.
REQ-025 Back-to-back: next command accepted in cycle after RESP; minimum 4 cycles per transfer.
REQ-026 cmd_valid while not ready SHALL be ignored; caller holds cmd_* until accepted.

Reset
REQ-027 HRESET=1 SHALL immediately force state IDLE, HTRANS=00, HADDR=0, HWRITE=0, HSIZE=000, HWDATA=0, rsp_valid=0, rsp_err=0, rsp_tmo=0, rsp_rdata=0, timeout counter=0.
REQ-028 cmd_ready SHALL be 0 while HRESET=1 and 1 from the first edge after deassertion.
REQ-029 Reset mid-transfer SHALL abandon it with no response pulse.

Configuration
REQ-030 Macro AHBM_TIMEOUT_EN defined: counter counts consecutive HREADY-low cycles in ADDR/DATA, clears on HREADY=1 and on entry to ADDR; on reaching TIMEOUT go RESP with rsp_err=1, rsp_tmo=1, HTRANS forced IDLE.
REQ-031 Macro undefined: no counter logic; rsp_tmo tied 0; transfer waits indefinitely on HREADY.

Verification
REQ-032 Word write 0x40000000 data 0x0000A5A5, HREADY=1 -> NONSEQ cycle N+1, HWDATA=0x0000A5A5 cycle N+2, rsp_valid N+3, rsp_err=0.
REQ-033 Word read 0x40000004, slave 2 wait states then HRDATA=0x0000FFFF -> rsp_valid N+5, rsp_rdata=0x0000FFFF.
REQ-034 Read with two-cycle ERROR (HRESP=1/HREADY=0 then HRESP=1/HREADY=1) -> rsp_err=1, rsp_rdata=0, HTRANS stays IDLE.
REQ-035 Halfword write at 0x40000001 -> no NONSEQ ever driven, rsp_valid cycle N+1, rsp_err=1.
REQ-036 With AHBM_TIMEOUT_EN, TIMEOUT=8, HREADY held 0 in DATA -> rsp_valid after 8 low cycles, rsp_err=1, rsp_tmo=1; without macro, no rsp_valid for 2000 cycles.
REQ-037 HRESET pulsed during DATA wait -> HTRANS=00 and state IDLE same cycle, no rsp_valid, next command completes normally.
